crc3_frame_checker: RTL
=======================

CRC3_FRAME_CHECKER -- requirements
Module: crc3_frame_checker

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; clk is sampled on the rising edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en  input  1  bit-accept enable; bit_in consumed on a rising edge only when en=1.
REQ-005 bit_in  input  1  serial frame bit, MSB-first: 5 message bits, then 3 CRC bits.
REQ-006 clr  input  1  synchronous abort of any partial frame; counters untouched.
REQ-007 frame_valid  output  1  one-cycle pulse: frame result registers updated.
REQ-008 msg_out  output  5  message bits of last completed frame.
REQ-009 crc_ok  output  1  last completed frame had zero remainder.
REQ-010 bit_cnt  output  3  bits accepted in current frame (0..7).
REQ-011 err_cnt  output  8  count of failed frames, saturating.

Function
REQ-012 Polynomial SHALL be x^3+x+1; frames SHALL be 8 bits: 5 message bits plus 3 CRC bits from the upstream CRC-3 generator.
REQ-013 Per accepted bit: fb=rem[2]; rem <= {rem[1:0],bit_in} XOR (fb ? 3'b011 : 3'b000).
REQ-014 Accepted bits SHALL also shift into an 8-bit shift register, MSB first.
REQ-015 FSM states SHALL be IDLE (bit_cnt=0, rem=0) and RECV (1..7 bits held).
REQ-016 IDLE -> RECV on accepted bit; RECV stays RECV while bit_cnt<7; accepting the 8th bit returns to IDLE.
REQ-017 On the edge accepting the 8th bit: frame_valid=1 next cycle; msg_out=shift[7:3]; crc_ok=1 iff the final remainder is 000; rem, shift and bit_cnt clear.
REQ-018 Latency: result visible exactly 1 cycle after the 8th-bit edge; msg_out and crc_ok hold until the next completed frame.
REQ-019 frame_valid SHALL be high for exactly one cycle per frame.
REQ-020 en=0 mid-frame SHALL pause: no state change, partial frame retained.
REQ-021 Back-to-back frames SHALL be supported: a bit accepted in the frame_valid cycle is bit 0 of the next frame.
REQ-022 clr=1 SHALL return to IDLE, zero rem/shift/bit_cnt, and override a simultaneous en; the 8th bit is discarded if coincident with clr, and no frame_valid is raised.
REQ-023 err_cnt SHALL increment by 1 on each frame with crc_ok=0 and saturate at 255.

Reset
REQ-024 On rst: state IDLE; frame_valid=0, msg_out=0, crc_ok=0, bit_cnt=0, err_cnt=0, rem=0, shift=0.
REQ-025 rst SHALL take priority over clr and en; reset mid-frame discards the partial frame.

Configuration
REQ-026 Macro CRC3_ERR_CNT_EN: when defined, err_cnt is implemented per REQ-023.
REQ-027 When CRC3_ERR_CNT_EN is undefined, err_cnt SHALL be constant 0 and no counter flops exist; all other behaviour is unchanged.

Structure
REQ-028 Package crc3_pkg SHALL hold CRC3_POLY (3'b011, implicit x^3), FRAME_LEN=8, MSG_LEN=5, CRC_LEN=3 and the FSM state enum.
REQ-029 Sub-module crc3_rem_step SHALL implement REQ-013 combinationally; crc3_frame_checker instantiates it once.

Verification
REQ-030 en=1, bits 10101101 -> 1 cycle after the 8th bit: frame_valid=1, msg_out=5'h15, crc_ok=1, err_cnt=0.
REQ-031 Bits 10101100 -> crc_ok=0, msg_out=5'h15, err_cnt=1 (0 without CRC3_ERR_CNT_EN).
REQ-032 Two frames 10101101 then 00000000 with no gap -> two frame_valid pulses 8 cycles apart, both crc_ok=1, second msg_out=0.
REQ-033 Bits 1010, en=0 for 3 cycles, then 1101 -> bit_cnt holds 4 during the pause; result identical to REQ-030.
REQ-034 clr after 3 bits (then full 10101101), and separately rst after 5 bits -> no frame_valid for the partial frame; next full frame gives crc_ok=1.
REQ-035 Force err_cnt to 255 with 256 bad frames, then send one more bad frame -> err_cnt stays 255.

Source files
------------

// File: rtl/crc3_pkg.sv
// Shared constants and FSM state type for the CRC-3 (x^3+x+1) frame checker.
// The CRC3_ERR_CNT_EN build macro is consumed by crc3_frame_checker, not here.
package crc3_pkg;

  localparam int FRAME_LEN = 8;
  localparam int MSG_LEN   = 5;
  localparam int CRC_LEN   = 3;
  localparam int CNT_W     = 3;
  localparam int ERR_W     = 8;

  // Low-order taps of x^3+x+1; the x^3 term is implicit in the feedback bit.
  localparam logic [CRC_LEN-1:0] CRC3_POLY = 3'b011;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/crc3_rem_step.sv
// One serial CRC-3 remainder update: shift bit_in into rem and fold in the
// polynomial whenever the outgoing MSB is set.
module crc3_rem_step
  import crc3_pkg::*;
(
  input  logic [CRC_LEN-1:0] rem,
  input  logic               bit_in,
  output logic [CRC_LEN-1:0] rem_next
);

  assign rem_next = {rem[CRC_LEN-2:0], bit_in} ^ (rem[CRC_LEN-1] ? CRC3_POLY : '0);

endmodule

// File: rtl/crc3_frame_checker.sv
// Serial 8-bit frame receiver (5 message + 3 CRC bits) that checks the CRC-3
// remainder. Define CRC3_ERR_CNT_EN to build the saturating failed-frame counter.
module crc3_frame_checker
  import crc3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               bit_in,
  input  logic               clr,
  output logic               frame_valid,
  output logic [MSG_LEN-1:0] msg_out,
  output logic               crc_ok,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic [ERR_W-1:0]   err_cnt
);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [CRC_LEN-1:0]     rem_reg, rem_next, rem_step_out;
  logic [FRAME_LEN-1:0]   shift_reg, shift_next, shift_in;
  logic                   frame_valid_reg;
  logic [MSG_LEN-1:0]     msg_out_reg;
  logic                   crc_ok_reg;
  logic                   last_bit;
  logic                   frame_done;

  crc3_rem_step u_rem_step (
    .rem      (rem_reg),
    .bit_in   (bit_in),
    .rem_next (rem_step_out)
  );

  assign shift_in = {shift_reg[FRAME_LEN-2:0], bit_in};
  assign last_bit = (state_reg == RECV) && (bit_cnt_reg == CNT_W'(FRAME_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; clr overrides any simultaneous en
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else if (en) begin
      case (state_reg)
        IDLE:    state_next = RECV;
        RECV:    state_next = last_bit ? IDLE : RECV;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    rem_next     = rem_reg;
    shift_next   = shift_reg;
    frame_done   = 1'b0;
    if (clr) begin
      bit_cnt_next = '0;
      rem_next     = '0;
      shift_next   = '0;
    end else if (en) begin
      if (last_bit) begin
        bit_cnt_next = '0;
        rem_next     = '0;
        shift_next   = '0;
        frame_done   = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        rem_next     = rem_step_out;
        shift_next   = shift_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg     <= '0;
      rem_reg         <= '0;
      shift_reg       <= '0;
      frame_valid_reg <= 1'b0;
      msg_out_reg     <= '0;
      crc_ok_reg      <= 1'b0;
    end else begin
      bit_cnt_reg     <= bit_cnt_next;
      rem_reg         <= rem_next;
      shift_reg       <= shift_next;
      frame_valid_reg <= frame_done;
      // Results come from the 8th bit's shifted/stepped values, not the cleared state
      if (frame_done) begin
        msg_out_reg <= shift_in[FRAME_LEN-1:CRC_LEN];
        crc_ok_reg  <= (rem_step_out == '0);
      end
    end
  end

`ifdef CRC3_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (frame_done && (rem_step_out != '0) && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = '0;
`endif

  assign frame_valid = frame_valid_reg;
  assign msg_out     = msg_out_reg;
  assign crc_ok      = crc_ok_reg;
  assign bit_cnt     = bit_cnt_reg;

endmodule
